// File: rtl/vjtag_cmd_pkg.sv
// rtl/vjtag_cmd_pkg.sv - opcodes, FSM states and status bit positions for vjtag_cmd_ctrl
package vjtag_cmd_pkg;

    localparam logic [3:0] OP_BYPASS = 4'd0;
    localparam logic [3:0] OP_ADDR   = 4'd1;
    localparam logic [3:0] OP_WRITE  = 4'd2;
    localparam logic [3:0] OP_READ   = 4'd3;
    localparam logic [3:0] OP_STATUS = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ST_BUSY = 0;
    localparam int ST_OVF  = 1;
    localparam int ST_ERR  = 2;

    // Unassigned IR codes behave exactly like BYPASS.
    function automatic logic [3:0] decode_op(input logic [3:0] ir);
        return (ir > OP_STATUS) ? OP_BYPASS : ir;
    endfunction

endpackage

// File: rtl/vjtag_dr_shift.sv
// rtl/vjtag_dr_shift.sv - DR capture/shift register, bypass bit and tdo mux
module vjtag_dr_shift
    import vjtag_cmd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    input  logic [3:0]        op,
    input  logic              cdr,
    input  logic              sdr,
    input  logic [ADDR_W-1:0] addr_q,
    input  logic [DATA_W-1:0] rdata_q,
    input  logic [2:0]        status,
    output logic [DATA_W-1:0] sr,
    output logic              tdo
);

    logic              byp_q;
    logic [DATA_W-1:0] cap;

    // Value loaded into the shift register on Capture-DR for the selected opcode.
    always_comb begin
        cap = '0;
        case (op)
            OP_ADDR:   cap[ADDR_W-1:0] = addr_q;
            OP_READ:   cap = rdata_q;
            OP_STATUS: cap[2:0] = status;
            default:   cap = '0;
        endcase
    end

    // Capture then shift LSB-first; BYPASS only touches its own 1-bit register.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            sr    <= '0;
            byp_q <= 1'b0;
        end else if (op == OP_BYPASS) begin
            if (cdr)
                byp_q <= 1'b0;
            else if (sdr)
                byp_q <= tdi;
        end else begin
            if (cdr)
                sr <= cap;
            else if (sdr)
                sr <= {tdi, sr[DATA_W-1:1]};
        end
    end

    assign tdo = (op == OP_BYPASS) ? byp_q : sr[0];

endmodule

// File: rtl/vjtag_cmd_ctrl.sv
// rtl/vjtag_cmd_ctrl.sv - virtual JTAG command sequencer to req/ack bus (option: VJTAG_CMD_AUTOINC_EN)
module vjtag_cmd_ctrl
    import vjtag_cmd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              tck,
    input  logic              rst_n,
    input  logic              tdi,
    output logic              tdo,
    input  logic [3:0]        ir_in,
    output logic [3:0]        ir_out,
    input  logic              virtual_state_cdr,
    input  logic              virtual_state_sdr,
    input  logic              virtual_state_udr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    logic [3:0]        op;
    logic [DATA_W-1:0] sr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              busy;
    logic              ovf;
    logic              err;
    logic [2:0]        status;
    logic [15:0]       cnt;
    logic              launch;
    state_t            state;
`ifdef VJTAG_CMD_AUTOINC_EN
    logic              prefetch_q;
`endif

    assign op = decode_op(ir_in);

    assign launch = virtual_state_udr &&
                    ((op == OP_ADDR) || (op == OP_WRITE) || (op == OP_READ));

    assign status[ST_BUSY] = busy;
    assign status[ST_OVF]  = ovf;
    assign status[ST_ERR]  = err;

    vjtag_dr_shift #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dr (
        .tck     (tck),
        .rst_n   (rst_n),
        .tdi     (tdi),
        .op      (op),
        .cdr     (virtual_state_cdr),
        .sdr     (virtual_state_sdr),
        .addr_q  (addr_q),
        .rdata_q (rdata_q),
        .status  (status),
        .sr      (sr),
        .tdo     (tdo)
    );

    // Transaction FSM, sticky flags and address register; flag sets are written
    // after the STATUS clear so a same-cycle set wins.
    always_ff @(posedge tck or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ir_out    <= 4'b0001;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
`ifdef VJTAG_CMD_AUTOINC_EN
            prefetch_q <= 1'b0;
`endif
        end else begin
            ir_out <= {err, ovf, busy, 1'b1};

            if (virtual_state_udr && (op == OP_STATUS)) begin
                ovf <= 1'b0;
                err <= 1'b0;
            end

            if (launch && (state != IDLE))
                ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= (op == OP_WRITE);
                        bus_addr  <= (op == OP_ADDR) ? sr[ADDR_W-1:0] : addr_q;
                        bus_wdata <= sr;
                        busy      <= 1'b1;
                        cnt       <= '0;
`ifdef VJTAG_CMD_AUTOINC_EN
                        prefetch_q <= (op == OP_ADDR);
`endif
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we)
                            rdata_q <= bus_rdata;
`ifdef VJTAG_CMD_AUTOINC_EN
                        if (!prefetch_q)
                            addr_q <= addr_q + ADDR_W'(1);
`endif
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        err     <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // An ADDR update always lands, even when its prefetch is dropped.
            if (virtual_state_udr && (op == OP_ADDR))
                addr_q <= sr[ADDR_W-1:0];
        end
    end

endmodule

// File: tb/tb_vjtag_cmd_ctrl.sv
// tb/tb_vjtag_cmd_ctrl.sv - randomized self-checking bench for vjtag_cmd_ctrl
module tb_vjtag_cmd_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 8;

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          tdi = 1'b0;
    logic          tdo;
    logic [3:0]    ir_in = 4'd0;
    logic [3:0]    ir_out;
    logic          cdr = 1'b0;
    logic          sdr = 1'b0;
    logic          udr = 1'b0;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic          bus_ack = 1'b0;

    vjtag_cmd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .tck               (tck),
        .rst_n             (rst_n),
        .tdi               (tdi),
        .tdo               (tdo),
        .ir_in             (ir_in),
        .ir_out            (ir_out),
        .virtual_state_cdr (cdr),
        .virtual_state_sdr (sdr),
        .virtual_state_udr (udr),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_rdata         (bus_rdata),
        .bus_ack           (bus_ack)
    );

    always #5 tck = ~tck;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t          exp_q[$];
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err   = 0;
    bit            m_ovf   = 0;

    int            cur_lat    = 0;
    logic [DW-1:0] cur_rdv    = '0;
    int            req_cycles = 0;
    int            last_len   = 0;
    txn_t          snap;

    // Bus slave: acks after cur_lat request cycles (0 = never), checks the
    // request against the model, and throws stray acks when no request is up.
    initial begin
        forever begin
            @(negedge tck);
            if (bus_req) begin
                if (req_cycles == 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_req", 1, 0);
                        snap.we = bus_we; snap.addr = bus_addr; snap.wdata = bus_wdata;
                    end else begin
                        snap = exp_q.pop_front();
                        check("bus_we", bus_we, snap.we);
                        check("bus_addr", bus_addr, snap.addr);
                        if (snap.we) check("bus_wdata", bus_wdata, snap.wdata);
                    end
                end else begin
                    check("hold_we", bus_we, snap.we);
                    check("hold_addr", bus_addr, snap.addr);
                    if (snap.we) check("hold_wdata", bus_wdata, snap.wdata);
                end
                req_cycles++;
                if (cur_lat != 0 && req_cycles == cur_lat) begin
                    bus_ack   = 1'b1;
                    bus_rdata = cur_rdv;
                end else begin
                    bus_ack   = 1'b0;
                    bus_rdata = $urandom;
                end
            end else begin
                if (req_cycles != 0) last_len = req_cycles;
                req_cycles = 0;
                bus_ack    = ($urandom_range(0, 3) == 0);
                bus_rdata  = $urandom;
            end
        end
    end

    // One full DR scan for opcode op, then the model's view of what follows.
    // dbl fires a second Update-DR while busy; rst_at>0 resets mid-transaction.
    task automatic do_cmd(input logic [3:0] op, input logic [DW-1:0] din, input int lat,
                          input logic [DW-1:0] rdv, input bit dbl, input int rst_at);
        logic [3:0]    dop;
        logic [DW-1:0] exp_cap;
        logic [DW-1:0] got;
        bit            launch;
        txn_t          t;
        dop = (op > 4'd4) ? 4'd0 : op;
        exp_cap = '0;
        case (dop)
            4'd0: exp_cap = {din[DW-2:0], 1'b0};
            4'd1: exp_cap[AW-1:0] = m_addr;
            4'd3: exp_cap = m_rdata;
            4'd4: exp_cap[2:0] = {m_err, m_ovf, 1'b0};
            default: exp_cap = '0;
        endcase
        got = '0;
        @(negedge tck); ir_in = op; cdr = 1'b1;
        @(negedge tck); cdr = 1'b0;
        for (int i = 0; i < DW; i++) begin
            got[i] = tdo;
            tdi = din[i];
            sdr = 1'b1;
            @(negedge tck);
        end
        sdr = 1'b0;
        check("dr_out", got, exp_cap);
        launch = (dop == 4'd1) || (dop == 4'd2) || (dop == 4'd3);
        if (dop == 4'd1) m_addr = din[AW-1:0];
        if (launch) begin
            t.we = (dop == 4'd2); t.addr = m_addr; t.wdata = din;
            exp_q.push_back(t);
            cur_lat = lat;
            cur_rdv = rdv;
        end
        if (dop == 4'd4) begin m_err = 0; m_ovf = 0; end
        last_len = 0;
        udr = 1'b1;
        @(negedge tck); udr = 1'b0;
        if (dbl) begin
            @(negedge tck); udr = 1'b1;
            @(negedge tck); udr = 1'b0;
            m_ovf = 1;
            @(negedge tck);
            check("ir_out_busy", ir_out, {m_err, 1'b1, 1'b1, 1'b1});
        end
        if (rst_at > 0) begin
            repeat (rst_at) @(negedge tck);
            rst_n = 1'b0;
            #1;
            check("rst_bus_req", bus_req, 0);
            check("rst_ir_out", ir_out, 4'b0001);
            check("rst_tdo", tdo, 0);
            m_addr = '0; m_rdata = '0; m_err = 0; m_ovf = 0;
            exp_q.delete();
            @(negedge tck); rst_n = 1'b1;
        end
        repeat (TO + 4) @(negedge tck);
        if (launch && rst_at == 0) begin
            check("req_len", last_len, (lat != 0) ? lat : TO);
            if (lat == 0) begin
                m_err = 1;
            end else begin
                if (dop != 4'd2) m_rdata = rdv;
`ifdef VJTAG_CMD_AUTOINC_EN
                if (dop != 4'd1) m_addr = m_addr + 1'b1;
`endif
            end
        end
        check("ir_out", ir_out, {m_err, m_ovf, 1'b0, 1'b1});
        check("txn_issued", exp_q.size(), 0);
    endtask

    initial begin
        int r;
        logic [3:0] op;
        repeat (3) @(negedge tck);
        check("reset_tdo", tdo, 0);
        check("reset_ir_out", ir_out, 4'b0001);
        check("reset_bus_req", bus_req, 0);
        check("reset_bus_we", bus_we, 0);
        check("reset_bus_addr", bus_addr, 0);
        check("reset_bus_wdata", bus_wdata, 0);
        rst_n = 1'b1;

        do_cmd(4'd1, 32'h0000_0010, 3, 32'hCAFE_F00D, 0, 0);
        do_cmd(4'd3, $urandom, 2, $urandom, 0, 0);
        do_cmd(4'd1, 32'h0000_0020, 1, $urandom, 0, 0);
        do_cmd(4'd2, 32'h1234_5678, 4, $urandom, 0, 0);
        do_cmd(4'd4, 32'h0, 1, 0, 0, 0);
        do_cmd(4'd2, $urandom, 0, $urandom, 0, 0);
        do_cmd(4'd4, 32'h0, 1, 0, 0, 0);
        do_cmd(4'd4, 32'h0, 1, 0, 0, 0);
        do_cmd(4'd2, $urandom, 0, $urandom, 1, 0);
        do_cmd(4'd4, 32'h0, 1, 0, 0, 0);
        do_cmd(4'hF, 32'h0000_000B, 1, 0, 0, 0);
        do_cmd(4'd0, $urandom, 1, 0, 0, 0);
        do_cmd(4'd1, 32'h0000_FFFF, 2, $urandom, 0, 0);
        do_cmd(4'd2, $urandom, 2, $urandom, 0, 0);
        do_cmd(4'd2, $urandom, 3, $urandom, 0, 0);
        do_cmd(4'd1, $urandom, 1, $urandom, 0, 0);

        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) op = 4'(r);
            else if (r == 5) op = 4'($urandom_range(5, 15));
            else op = 4'($urandom_range(1, 3));
            do_cmd(op, $urandom, $urandom_range(0, 6), $urandom, 0, 0);
        end

        do_cmd(4'd2, $urandom, 0, $urandom, 0, 3);
        do_cmd(4'd4, 32'h0, 1, 0, 0, 0);
        do_cmd(4'd3, $urandom, 2, $urandom, 0, 0);
        do_cmd(4'd3, $urandom, 2, $urandom, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
